mips32_mem_responder: RTL and testbench
=======================================

Name: mips32_mem_responder

Overview:
- Memory-side responder for the MIPS32 pipeline: owns the 1024 x 32 word-addressed memory and serves two initiators, the instruction-fetch port (read-only) and the data port (LW/SW).
- Valid/ready request handshake, round-robin arbitration between ports, programmable wait states, and a single-cycle response pulse per transaction.
- Replaces direct array access from the pipeline; the pipeline stalls on ready/rsp_valid.

Parameters:
- DEPTH, 1024, number of 32-bit words; legal addresses are 0..DEPTH-1.
- WAIT_STATES, 1, extra BUSY cycles between accept and response (0..15).

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- i_req_valid  in  1  fetch request.
- i_req_addr  in  32  fetch word address (PC).
- i_req_ready  out  1  fetch request accepted this cycle.
- i_rsp_valid  out  1  fetch response pulse.
- i_rsp_data  out  32  instruction word.
- i_rsp_err  out  1  fetch address out of range.
- d_req_valid  in  1  data request.
- d_req_we  in  1  1 = store (SW), 0 = load (LW).
- d_req_addr  in  32  data word address (ALUout).
- d_req_wdata  in  32  store data (B operand).
- d_req_ready  out  1  data request accepted this cycle.
- d_rsp_valid  out  1  data response pulse.
- d_rsp_data  out  32  load data; 0 for stores.
- d_rsp_err  out  1  data address out of range.

Behaviour:
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE, wait counter 0, last_grant = FETCH, and all rsp outputs 0. Memory contents are not cleared by reset.
- Ready signals are combinational and asserted only in IDLE, for the selected port only. An initiator holds valid and its payload stable until it sees ready.
- Arbitration in IDLE:
  - Only one valid: that port is selected.
  - Both valid: the port not equal to last_grant is selected.
  - After reset, simultaneous requests therefore go to the data port first.
- Accept edge (IDLE with selected valid): latch port, addr, we and wdata; update last_grant.
  - WAIT_STATES = 0: go to RESP.
  - Otherwise: go to BUSY with counter = WAIT_STATES.
- BUSY: decrement the counter each cycle. Move to RESP on the edge where the counter goes from 1 to 0. No new requests are accepted.
- Entry edge into RESP:
  - Read: rsp_data is registered from MEM[addr].
  - Store: MEM[addr] <= wdata is committed on this edge, and rsp_data = 0.
  - Out-of-range address (addr >= DEPTH): no memory access, rsp_data = 0, rsp_err = 1.
- RESP lasts exactly one cycle. The latched port's rsp_valid is 1; the other port's rsp_valid is 0. Next state is IDLE.
- Timing:
  - Accept at edge T gives rsp_valid high during cycle T+WAIT_STATES+1.
  - Throughput is one transaction per WAIT_STATES+2 cycles.
- Ordering: a load that follows a store to the same address returns the new data. No bypass logic is needed because transactions are serialised.
- Fetch-port writes are impossible because the fetch port has no we input.
- rsp_data and rsp_err hold their values outside RESP. Only rsp_valid qualifies them.
- Reset mid-operation (BUSY or RESP): return to IDLE next edge, drop the pending transaction, suppress its write if not yet committed, and force rsp_valid to 0.
- Address width rule: the full 32-bit address is compared against DEPTH; the index into the array is addr[log2(DEPTH)-1:0].

Decomposition:
- Shared package mips32_mem_pkg holds:
  - the state enum (IDLE/BUSY/RESP);
  - the port-select constants PORT_FETCH/PORT_DATA;
  - the DEPTH default and its derived index width.
- One natural sub-module, mips32_mem_arbiter: combinational two-way round-robin select plus the registered last_grant bit.
- The storage array stays in the top level.

Test Plan:
- Reset, then a data store of 0xDEADBEEF to addr 5, then a data load from addr 5, with WAIT_STATES=1 -> store rsp at accept+2 with d_rsp_data=0 and err=0; load rsp returns 0xDEADBEEF.
- i_req_valid and d_req_valid both asserted, held for two transactions, first request after reset -> data served first, fetch second; i_rsp_valid and d_rsp_valid never high in the same cycle.
- d_req_valid held continuously while fetch requests addrs 0,1,2 -> grants alternate D,I,D,I; no port waits more than one transaction.
- Load from addr 1024 and addr 0xFFFFFFFF -> d_rsp_err=1, d_rsp_data=0; a following store to 1024 leaves MEM[0] unchanged.
- WAIT_STATES=0 and WAIT_STATES=3 builds, fetch from addr 7 -> i_rsp_valid exactly 1 and 4 cycles after the accept edge respectively; ready low throughout BUSY and RESP.
- Store to addr 9 accepted, rst pulsed during BUSY -> no rsp_valid; a later load from addr 9 returns its pre-store value; the next request after reset is accepted in the first IDLE cycle.

Source files
------------

// File: rtl/mips32_mem_pkg.sv
// Shared types and constants for the MIPS32 memory responder.
package mips32_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam int unsigned MEM_DEPTH = 1024;
    localparam int unsigned MEM_IDX_W = $clog2(MEM_DEPTH);

endpackage

// File: rtl/mips32_mem_arbiter.sv
// Two-way round-robin select between the fetch and data ports.
module mips32_mem_arbiter
    import mips32_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic fetch_valid,
    input  logic data_valid,
    input  logic accept,
    output logic sel
);

    logic last_grant_q;

    always_comb begin
        sel = PORT_FETCH;
        if (fetch_valid && data_valid) begin
            sel = ~last_grant_q;
        end else if (data_valid) begin
            sel = PORT_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= PORT_FETCH;
        end else if (accept) begin
            last_grant_q <= sel;
        end
    end

endmodule

// File: rtl/mips32_mem_responder.sv
// Word-addressed memory shared by the fetch and data ports, with wait states and
// a one-cycle response pulse per transaction.
module mips32_mem_responder
    import mips32_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = MEM_DEPTH,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    output logic        i_req_ready,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_data,
    output logic        i_rsp_err,
    input  logic        d_req_valid,
    input  logic        d_req_we,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_req_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err
);

    localparam int unsigned IdxW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        port_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic            sel;
    logic            accept;
    logic            go_resp;
    logic            acc_port;
    logic            acc_we;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;
    logic            acc_oor;
    logic [IdxW-1:0] acc_idx;

    mips32_mem_arbiter u_arbiter (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (i_req_valid),
        .data_valid  (d_req_valid),
        .accept      (accept),
        .sel         (sel)
    );

    // With zero wait states the accept edge is also the RESP entry edge, so the
    // access uses the live request; otherwise it uses the latched one.
    always_comb begin
        accept      = (state_q == StIdle) && (i_req_valid || d_req_valid);
        i_req_ready = accept && (sel == PORT_FETCH);
        d_req_ready = accept && (sel == PORT_DATA);
        if (state_q == StIdle) begin
            acc_port  = sel;
            acc_we    = (sel == PORT_DATA) && d_req_we;
            acc_addr  = (sel == PORT_DATA) ? d_req_addr : i_req_addr;
            acc_wdata = d_req_wdata;
            go_resp   = accept && (WAIT_STATES == 0);
        end else begin
            acc_port  = port_q;
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            go_resp   = (state_q == StBusy) && (cnt_q == 4'd1);
        end
        acc_oor = acc_addr >= 32'(DEPTH);
        acc_idx = acc_addr[IdxW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst && go_resp && acc_we && !acc_oor) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            port_q      <= PORT_FETCH;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            i_rsp_valid <= 1'b0;
            i_rsp_data  <= 32'd0;
            i_rsp_err   <= 1'b0;
            d_rsp_valid <= 1'b0;
            d_rsp_data  <= 32'd0;
            d_rsp_err   <= 1'b0;
        end else begin
            i_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        port_q  <= sel;
                        we_q    <= acc_we;
                        addr_q  <= acc_addr;
                        wdata_q <= d_req_wdata;
                        if (!go_resp) begin
                            state_q <= StBusy;
                            cnt_q   <= 4'(WAIT_STATES);
                        end
                    end
                end
                StBusy:  cnt_q   <= cnt_q - 4'd1;
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            if (go_resp) begin
                state_q <= StResp;
                if (acc_port == PORT_FETCH) begin
                    i_rsp_valid <= 1'b1;
                    i_rsp_err   <= acc_oor;
                    i_rsp_data  <= acc_oor ? 32'd0 : mem[acc_idx];
                end else begin
                    d_rsp_valid <= 1'b1;
                    d_rsp_err   <= acc_oor;
                    d_rsp_data  <= (acc_oor || acc_we) ? 32'd0 : mem[acc_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Directed bench: one WAIT_STATES=1 responder exercised on both ports, plus
// WAIT_STATES=0 and WAIT_STATES=3 instances for latency and ready timing.
module tb_mips32_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_err;
    logic [31:0] i_req_addr, i_rsp_data;
    logic        d_req_valid, d_req_we, d_req_ready, d_rsp_valid, d_rsp_err;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;

    // Shared data-port stimulus and per-instance fetch signals for the other builds.
    logic        x_valid;
    logic        f0_valid, f0_ready, f0_rsp_valid, f0_rsp_err;
    logic        f3_valid, f3_ready, f3_rsp_valid, f3_rsp_err;
    logic [31:0] f0_rsp_data, f3_rsp_data;
    logic        z0_ready, z0_rsp_valid, z0_rsp_err;
    logic        z3_ready, z3_rsp_valid, z3_rsp_err;
    logic [31:0] z0_rsp_data, z3_rsp_data;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] grants;
    int          n_grants;

    mips32_mem_responder #(.DEPTH(1024), .WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid),
        .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err)
    );

    mips32_mem_responder #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .i_req_valid(f0_valid), .i_req_addr(32'd7), .i_req_ready(f0_ready),
        .i_rsp_valid(f0_rsp_valid), .i_rsp_data(f0_rsp_data), .i_rsp_err(f0_rsp_err),
        .d_req_valid(x_valid), .d_req_we(1'b1), .d_req_addr(32'd7),
        .d_req_wdata(32'h7777_0007), .d_req_ready(z0_ready), .d_rsp_valid(z0_rsp_valid),
        .d_rsp_data(z0_rsp_data), .d_rsp_err(z0_rsp_err)
    );

    mips32_mem_responder #(.DEPTH(1024), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst),
        .i_req_valid(f3_valid), .i_req_addr(32'd7), .i_req_ready(f3_ready),
        .i_rsp_valid(f3_rsp_valid), .i_rsp_data(f3_rsp_data), .i_rsp_err(f3_rsp_err),
        .d_req_valid(x_valid), .d_req_we(1'b1), .d_req_addr(32'd7),
        .d_req_wdata(32'h7777_0007), .d_req_ready(z3_ready), .d_rsp_valid(z3_rsp_valid),
        .d_rsp_data(z3_rsp_data), .d_rsp_err(z3_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where the response is visible.
    task automatic do_data(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_data,
                           input logic exp_err);
        int lat;
        d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr; d_req_wdata = wdata;
        #1;
        for (int c = 0; c < 20 && !d_req_ready; c++) begin
            @(negedge clk); #1;
        end
        chk({tag, "_ready"}, d_req_ready, 1);
        @(negedge clk);
        d_req_valid = 1'b0;
        lat = 1;
        while (!d_rsp_valid && lat < 20) begin
            @(negedge clk); lat++;
        end
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_data"}, d_rsp_data, exp_data);
        chk({tag, "_err"}, d_rsp_err, exp_err);
    endtask

    // Fetches from f_base.. and loads from addr 5, each initiator holding valid
    // until it sees ready; grant order is logged, DATA as 1.
    task automatic run_arb(input string tag, input int f_base, input int n_fetch,
                           input int n_data);
        int f_sent = 0, d_sent = 0, f_rsp = 0, d_rsp = 0;
        grants = 16'd0; n_grants = 0;
        for (int c = 0; c < 60; c++) begin
            if (f_rsp == n_fetch && d_rsp == n_data) break;
            i_req_valid = (f_sent < n_fetch); i_req_addr = 32'(f_base + f_sent);
            d_req_valid = (d_sent < n_data); d_req_we = 1'b0; d_req_addr = 32'd5;
            #1;
            chk({tag, "_excl"}, i_rsp_valid & d_rsp_valid, 0);
            if (i_rsp_valid) begin
                chk({tag, "_idata"}, i_rsp_data, 32'hA000_0000 + 32'(f_base + f_rsp));
                f_rsp++;
            end
            if (d_rsp_valid) begin
                chk({tag, "_ddata"}, d_rsp_data, 32'hDEAD_BEEF);
                d_rsp++;
            end
            if (i_req_ready) begin
                grants = {grants[14:0], 1'b0}; n_grants++; f_sent++;
            end
            if (d_req_ready) begin
                grants = {grants[14:0], 1'b1}; n_grants++; d_sent++;
            end
            @(negedge clk);
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        chk({tag, "_nfetch"}, f_rsp, n_fetch);
        chk({tag, "_ndata"}, d_rsp, n_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        i_req_valid = 1'b0; i_req_addr = 32'd0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = 32'd0; d_req_wdata = 32'd0;
        x_valid = 1'b0; f0_valid = 1'b0; f3_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_i_rsp_valid", i_rsp_valid, 0);
        chk("rst_d_rsp_valid", d_rsp_valid, 0);
        chk("rst_i_rsp_data", i_rsp_data, 0);
        chk("rst_d_rsp_data", d_rsp_data, 0);
        chk("rst_d_rsp_err", d_rsp_err, 0);
        chk("rst_ready", {i_req_ready, d_req_ready}, 0);
        rst = 1'b0;

        // Known contents for later fetches and range checks.
        for (int k = 0; k < 4; k++) begin
            do_data("pre", 1'b1, 32'(k), 32'hA000_0000 + 32'(k), 32'd0, 1'b0);
        end

        do_data("sw5", 1'b1, 32'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
        chk("sw5_no_irsp", i_rsp_valid, 0);
        do_data("lw5", 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0);

        do_data("lw1024", 1'b0, 32'd1024, 32'd0, 32'd0, 1'b1);
        do_data("lwffff", 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1);
        do_data("sw1024", 1'b1, 32'd1024, 32'h5555_5555, 32'd0, 1'b1);
        do_data("lw0", 1'b0, 32'd0, 32'd0, 32'hA000_0000, 1'b0);

        // Reset during BUSY must drop the store to 9.
        do_data("sw9a", 1'b1, 32'd9, 32'h1111_2222, 32'd0, 1'b0);
        @(negedge clk);
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'd9; d_req_wdata = 32'h9999_9999;
        #1 chk("rst9_accept", d_req_ready, 1);
        @(negedge clk);
        d_req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst9_rspv", d_rsp_valid, 0);
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'd9;
        #1 chk("rst9_first_idle", d_req_ready, 1);
        @(negedge clk);
        d_req_valid = 1'b0;
        chk("rst9_busy_rspv", d_rsp_valid, 0);
        @(negedge clk);
        chk("rst9_lw_valid", d_rsp_valid, 1);
        chk("rst9_lw_data", d_rsp_data, 32'h1111_2222);

        // Simultaneous requests right after reset: data first, then fetch.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_arb("both", 3, 1, 1);
        chk("both_ngrant", n_grants, 2);
        chk("both_order", 32'(grants[1:0]), 32'h2);

        run_arb("alt", 0, 3, 3);
        chk("alt_ngrant", n_grants, 6);
        chk("alt_order", 32'(grants[5:0]), 32'h2A);

        // Preload addr 7 in the WAIT_STATES=0 and =3 instances.
        x_valid = 1'b1;
        #1 chk("x_ready", {z0_ready, z3_ready}, 2'b11);
        @(negedge clk);
        x_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("x_rsp_data", z0_rsp_data | z3_rsp_data, 0);
        chk("x_rsp_err", {z0_rsp_err, z3_rsp_err, z0_rsp_valid, z3_rsp_valid}, 0);

        f0_valid = 1'b1;
        #1 chk("ws0_accept", f0_ready, 1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("ws0_rspv_%0d", k), f0_rsp_valid, (k == 1 || k == 3));
            chk($sformatf("ws0_ready_%0d", k), f0_ready, (k == 2));
            if (k == 1) begin
                chk("ws0_data", f0_rsp_data, 32'h7777_0007);
                chk("ws0_err", f0_rsp_err, 0);
            end
            if (k == 3) f0_valid = 1'b0;
        end

        f3_valid = 1'b1;
        #1 chk("ws3_accept", f3_ready, 1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("ws3_rspv_%0d", k), f3_rsp_valid, (k == 4 || k == 9));
            if (k <= 6) chk($sformatf("ws3_ready_%0d", k), f3_ready, (k == 5));
            if (k == 4) begin
                chk("ws3_data", f3_rsp_data, 32'h7777_0007);
                chk("ws3_err", f3_rsp_err, 0);
            end
            if (k == 6) f3_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
